// File: rtl/irq_gateway_pkg.sv
// Shared definitions for the interrupt gateway: register offsets, register
// select encoding and byte-lane helpers used by the CLIC-side address decode.
package irq_gateway_pkg;

   // Register byte offsets within the gateway window
   localparam logic [31:0] OFF_MODE = 32'h0000_0000;
   localparam logic [31:0] OFF_POL  = 32'h0000_0004;
   localparam logic [31:0] OFF_PEND = 32'h0000_0008;
   localparam logic [31:0] OFF_MASK = 32'h0000_000C;

   // Register select, taken from address bits [3:2]
   typedef enum logic [1:0] {
      REG_MODE = 2'd0,
      REG_POL  = 2'd1,
      REG_PEND = 2'd2,
      REG_MASK = 2'd3
   } reg_sel_e;

   // Expand per-byte write strobes into a per-bit mask
   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[b*8 +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

   // Merge new data into an old word on the enabled byte lanes only
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] m;
      m = strb_to_mask(strb);
      return (old_val & ~m) | (new_val & m);
   endfunction

   // Mask with the low n bits set (n in 1..32)
   function automatic logic [31:0] line_mask(input int n);
      if (n >= 32) begin
         return 32'hFFFF_FFFF;
      end
      return (32'h1 << n) - 32'h1;
   endfunction

endpackage

// File: rtl/irq_gateway_sync.sv
// Per-line synchronizer: SYNC_STAGES-deep flop chain bringing one raw
// interrupt line into the clk domain.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetb,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift the raw line one stage deeper each clock
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   // Synchronizer flops, cleared by reset so no stale level survives it
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway: synchronizes raw interrupt lines, applies polarity,
// edge/level conditioning and masking, and exposes MODE/POL/PEND/MASK
// through a simple request/accept register port.
module irq_gateway
   import irq_gateway_pkg::*;
#(
   parameter int NUM_INTERRUPTS = 32,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      resetb,
   input  logic [NUM_INTERRUPTS-1:0] irq_in,
   input  logic                      wready,
   output logic                      wvalid,
   input  logic [31:0]               waddr,
   input  logic [31:0]               wdata,
   input  logic [3:0]                wstrb,
   input  logic                      rready,
   output logic                      rvalid,
   input  logic [31:0]               raddr,
   output logic                      rresp,
   output logic [31:0]               rdata,
   output logic [31:0]               ex_irq
);

   localparam logic [31:0] LINE_MASK = line_mask(NUM_INTERRUPTS);

   logic [31:0] sync_out;
   logic [31:0] s_line;
   logic [31:0] edge_det;
   logic [31:0] w1c;
   reg_sel_e    wsel;
   reg_sel_e    rsel;

   logic [31:0] mode_q,    mode_d;
   logic [31:0] pol_q,     pol_d;
   logic [31:0] pend_q,    pend_d;
   logic [31:0] mask_q,    mask_d;
   logic [31:0] prev_q,    prev_d;
   logic [31:0] hist_ok_q, hist_ok_d;
   logic [31:0] rdata_q,   rdata_d;

   // Only address bits [3:2] select a register; the rest are don't-care
   logic unused_addr_bits;
   assign unused_addr_bits = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0]};

   // One synchronizer per implemented line; unimplemented lines tie to 0
   for (genvar i = 0; i < 32; i++) begin : g_line
      if (i < NUM_INTERRUPTS) begin : g_on
         irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .resetb (resetb),
            .d      (irq_in[i]),
            .q      (sync_out[i])
         );
      end else begin : g_off
         assign sync_out[i] = 1'b0;
      end
   end

   assign wsel = reg_sel_e'(waddr[3:2]);
   assign rsel = reg_sel_e'(raddr[3:2]);

   // Polarity-corrected line value; edges need a valid previous sample,
   // which is withheld for one cycle after MODE/POL changes so the
   // reconfiguration itself cannot look like an edge
   always_comb begin
      s_line   = (sync_out ^ pol_q) & LINE_MASK;
      edge_det = s_line & ~prev_q & hist_ok_q;
   end

   // Register writes, W1C decode and pending-state update
   always_comb begin
      mode_d = mode_q;
      pol_d  = pol_q;
      mask_d = mask_q;
      w1c    = '0;
      if (wready) begin
         case (wsel)
            REG_MODE: mode_d = merge_bytes(mode_q, wdata, wstrb) & LINE_MASK;
            REG_POL:  pol_d  = merge_bytes(pol_q, wdata, wstrb) & LINE_MASK;
            REG_PEND: w1c    = wdata & strb_to_mask(wstrb) & LINE_MASK;
            REG_MASK: mask_d = merge_bytes(mask_q, wdata, wstrb) & LINE_MASK;
            default:  w1c    = '0;
         endcase
      end
      // Edge lines: set beats clear. Level lines: follow the line directly.
      pend_d    = ((mode_q & ((pend_q & ~w1c) | edge_det)) | (~mode_q & s_line))
                  & LINE_MASK;
      prev_d    = s_line;
      hist_ok_d = ~((mode_d ^ mode_q) | (pol_d ^ pol_q));
   end

   // Read data capture from pre-write register values
   always_comb begin
      rdata_d = rdata_q;
      if (rready) begin
         case (rsel)
            REG_MODE: rdata_d = mode_q;
            REG_POL:  rdata_d = pol_q;
            REG_PEND: rdata_d = pend_q;
            REG_MASK: rdata_d = mask_q;
            default:  rdata_d = '0;
         endcase
      end
   end

   // State registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         mode_q    <= '0;
         pol_q     <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         prev_q    <= '0;
         hist_ok_q <= '0;
         rdata_q   <= '0;
      end else begin
         mode_q    <= mode_d;
         pol_q     <= pol_d;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         prev_q    <= prev_d;
         hist_ok_q <= hist_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   assign wvalid = wready;
   assign rvalid = rready;
   assign rresp  = 1'b1;
   assign rdata  = rdata_q;
   assign ex_irq = pend_q & mask_q;

endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway (16 lines, 2 synchronizer stages).
module tb_irq_gateway;

   localparam int NI = 16;

   logic          clk;
   logic          resetb;
   logic [NI-1:0] irq_in;
   logic          wready;
   logic          wvalid;
   logic [31:0]   waddr;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          rready;
   logic          rvalid;
   logic [31:0]   raddr;
   logic          rresp;
   logic [31:0]   rdata;
   logic [31:0]   ex_irq;

   int n_total;
   int n_bad;
   logic [31:0] rd;

   irq_gateway #(.NUM_INTERRUPTS(NI), .SYNC_STAGES(2)) dut (
      .clk    (clk),
      .resetb (resetb),
      .irq_in (irq_in),
      .wready (wready),
      .wvalid (wvalid),
      .waddr  (waddr),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .rready (rready),
      .rvalid (rvalid),
      .raddr  (raddr),
      .rresp  (rresp),
      .rdata  (rdata),
      .ex_irq (ex_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      wready = 1'b1; waddr = a; wdata = d; wstrb = s;
      @(posedge clk); #1;
      wready = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      rready = 1'b1; raddr = a;
      @(posedge clk); #1;
      rready = 1'b0; raddr = '0;
      d = rdata;
   endtask

   initial begin
      n_total = 0; n_bad = 0;
      resetb = 1'b0; irq_in = '0;
      wready = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
      rready = 1'b0; raddr = '0;

      // Reset state and combinational accepts
      repeat (2) @(posedge clk); #1;
      chk("rst_ex_irq", ex_irq, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      wready = 1'b1; rready = 1'b1; #1;
      chk("wvalid_follow", {31'b0, wvalid}, 32'h1);
      chk("rvalid_follow", {31'b0, rvalid}, 32'h1);
      chk("rresp_one", {31'b0, rresp}, 32'h1);
      wready = 1'b0; rready = 1'b0;
      @(negedge clk); resetb = 1'b1;

      // Level mode latency on line 0
      bus_write(32'hC, 32'h1, 4'hF);
      @(posedge clk); #1 irq_in[0] = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("lvl_rise_early", ex_irq, 32'h0);
      @(posedge clk); #1;
      chk("lvl_rise_3clk", ex_irq, 32'h1);
      irq_in[0] = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("lvl_fall_early", ex_irq, 32'h1);
      @(posedge clk); #1;
      chk("lvl_fall_3clk", ex_irq, 32'h0);

      // Edge mode on line 1: pulse latches, W1C clears
      bus_write(32'h0, 32'h2, 4'hF);
      bus_write(32'hC, 32'h2, 4'hF);
      @(posedge clk); #1 irq_in[1] = 1'b1;
      @(posedge clk); #1 irq_in[1] = 1'b0;
      repeat (5) @(posedge clk); #1;
      bus_read(32'h8, rd);
      chk("edge_pend_held", rd, 32'h2);
      chk("edge_ex_irq", ex_irq, 32'h2);
      bus_write(32'h8, 32'h2, 4'hF);
      chk("edge_w1c_ex", ex_irq, 32'h0);
      bus_read(32'h8, rd);
      chk("edge_w1c_pend", rd, 32'h0);

      // Collision: edge on line 3 lands on the same edge as a W1C of bit 3
      bus_write(32'h0, 32'hA, 4'hF);
      @(posedge clk); #1 irq_in[3] = 1'b1;
      @(posedge clk); #1 irq_in[3] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      wready = 1'b1; waddr = 32'h8; wdata = 32'h8; wstrb = 4'hF;
      @(posedge clk); #1;
      wready = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
      bus_read(32'h8, rd);
      chk("collide_set_wins", rd, 32'h8);
      bus_write(32'h8, 32'h8, 4'h2);
      bus_read(32'h8, rd);
      chk("w1c_lane_off", rd, 32'h8);
      bus_write(32'h8, 32'h8, 4'h1);
      bus_read(32'h8, rd);
      chk("w1c_lane_on", rd, 32'h0);

      // POL change on an idle edge line must not fabricate an edge
      bus_write(32'h0, 32'h2A, 4'hF);
      bus_write(32'h4, 32'h20, 4'hF);
      repeat (5) @(posedge clk); #1;
      bus_read(32'h8, rd);
      chk("pol_chg_no_edge", rd, 32'h0);
      bus_write(32'h4, 32'h0, 4'hF);

      // Polarity on level line 4, then masking
      bus_write(32'h0, 32'h0, 4'hF);
      bus_write(32'h4, 32'h10, 4'hF);
      bus_write(32'hC, 32'h10, 4'hF);
      repeat (5) @(posedge clk); #1;
      chk("pol_ex_irq", ex_irq, 32'h10);
      bus_write(32'hC, 32'h0, 4'hF);
      chk("pol_masked", ex_irq, 32'h0);
      bus_read(32'h8, rd);
      chk("pol_pend", rd, 32'h10);

      // Byte lanes, read timing, upper-bit decode and read-before-write
      bus_write(32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h1);
      bus_read(32'hC, rd);
      chk("mask_lane0", rd, 32'hFF);
      @(negedge clk);
      rready = 1'b1; raddr = 32'h0;
      chk("rdata_before_edge", rdata, 32'hFF);
      @(posedge clk); #1;
      rready = 1'b0; raddr = '0;
      chk("rdata_after_edge", rdata, 32'h0);
      repeat (2) @(posedge clk); #1;
      chk("rdata_holds", rdata, 32'h0);
      @(negedge clk);
      wready = 1'b1; waddr = 32'hC; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      rready = 1'b1; raddr = 32'hC;
      @(posedge clk); #1;
      wready = 1'b0; rready = 1'b0; waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
      chk("rd_wr_same_reg", rdata, 32'hFF);
      bus_read(32'hC, rd);
      chk("mask_upper_zero", rd, 32'hFFFF);
      chk("ex_irq_upper", ex_irq, 32'h10);

      // Reset while PEND = 0x5
      bus_write(32'h4, 32'h0, 4'hF);
      @(posedge clk); #1 irq_in = 16'h0005;
      repeat (5) @(posedge clk); #1;
      bus_read(32'h8, rd);
      chk("pre_rst_pend", rd, 32'h5);
      chk("pre_rst_ex", ex_irq, 32'h5);
      @(posedge clk); #3 resetb = 1'b0;
      #1;
      chk("async_rst_ex", ex_irq, 32'h0);
      chk("async_rst_rdata", rdata, 32'h0);
      irq_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); resetb = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("post_rst_ex", ex_irq, 32'h0);
      bus_read(32'h0, rd);
      chk("post_rst_mode", rd, 32'h0);
      bus_read(32'h4, rd);
      chk("post_rst_pol", rd, 32'h0);
      bus_read(32'h8, rd);
      chk("post_rst_pend", rd, 32'h0);
      bus_read(32'hC, rd);
      chk("post_rst_mask", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
